issue_scheduler: RTL and testbench



---
 rtl/pipeline_pkg.sv | 50 +++++
 rtl/issue_scheduler_pair_check.sv | 51 +++++
 rtl/issue_scheduler.sv | 115 +++++++++++
 tb/tb_issue_scheduler.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline types for the RV32I core front end.
// Decoded instruction bundle plus issue helpers.
package pipeline_pkg;

    typedef enum logic [2:0] {
        ALU_TYPE,
        LD_TYPE,
        ST_TYPE,
        BR_TYPE,
        SYS_TYPE
    } instr_type_e;

    typedef struct packed {
        logic        valid;
        instr_type_e instr_type;
        logic        load_en;
        logic        store_en;
        logic        prd_en;
        logic        wren;
        logic        use_rs1;
        logic        use_rs2;
        logic [4:0]  rd_addr;
        logic [4:0]  rs1_addr;
        logic [4:0]  rs2_addr;
        logic [31:0] imm;
        logic [31:0] pc;
    } decode_t;

    typedef enum logic {
        ISSUE,
        SPLIT
    } issue_state_e;

    localparam decode_t BUBBLE = '0;

    function automatic logic v_capable(input decode_t d);
        return !d.load_en && !d.store_en && !d.prd_en &&
               (d.instr_type != SYS_TYPE);
    endfunction

    function automatic logic raw_hazard(input decode_t a,
                                        input decode_t b);
        logic rs1_hit;
        logic rs2_hit;
        rs1_hit = b.use_rs1 && (b.rs1_addr == a.rd_addr);
        rs2_hit = b.use_rs2 && (b.rs2_addr == a.rd_addr);
        return a.wren && (a.rd_addr != 5'd0) && (rs1_hit || rs2_hit);
    endfunction

endpackage

// File: rtl/issue_scheduler_pair_check.sv
// Co-issue and load-use decisions for the dual-issue scheduler.
// Purely combinational; the FSM lives in issue_scheduler.
module issue_pair_check
    import pipeline_pkg::*;
(
    input  decode_t    i_slot0,
    input  decode_t    i_slot1,
    input  decode_t    i_held,
    input  logic [4:0] i_ld_rd,
    input  logic       i_ld_vld,
    output decode_t    o_first,
    output decode_t    o_second,
    output logic       o_first_lu,
    output logic       o_held_lu,
    output logic       o_co_issue
);

    decode_t ld;
    logic    second_lu;
    logic    waw;

    always_comb begin
        ld         = BUBBLE;
        ld.valid   = i_ld_vld;
        ld.load_en = i_ld_vld;
        ld.wren    = i_ld_vld;
        ld.rd_addr = i_ld_rd;

        // A lone younger instruction is promoted to the older slot.
        if (i_slot0.valid) begin
            o_first  = i_slot0;
            o_second = i_slot1;
        end else begin
            o_first  = i_slot1;
            o_second = BUBBLE;
        end

        o_first_lu = raw_hazard(ld, o_first);
        second_lu  = raw_hazard(ld, o_second);
        o_held_lu  = raw_hazard(ld, i_held);

        waw = o_first.wren && o_second.wren &&
              (o_first.rd_addr == o_second.rd_addr) &&
              (o_first.rd_addr != 5'd0);

        o_co_issue = o_second.valid && v_capable(o_second) &&
                     !raw_hazard(o_first, o_second) &&
                     !second_lu && !waw;
    end

endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue scheduler feeding the U and V execute pipes.
// Splits unpairable pairs and inserts load-use bubbles.
module issue_scheduler
    import pipeline_pkg::*;
(
    input  logic    i_clk,
    input  logic    i_rst_n,
    input  decode_t i_slot0,
    input  decode_t i_slot1,
    input  logic    i_flush,
    input  logic    i_stall,
    output decode_t o_u_issue,
    output decode_t o_v_issue,
    output logic    o_dec_hold
);

    issue_state_e state_q, state_d;
    decode_t      held_q, held_d;
    decode_t      u_q, u_d;
    decode_t      v_q, v_d;
    logic [4:0]   ld_rd_q, ld_rd_d;
    logic         ld_vld_q, ld_vld_d;

    decode_t first;
    decode_t second;
    logic    first_lu;
    logic    held_lu;
    logic    co_issue;

    issue_pair_check u_check (
        .i_slot0   (i_slot0),
        .i_slot1   (i_slot1),
        .i_held    (held_q),
        .i_ld_rd   (ld_rd_q),
        .i_ld_vld  (ld_vld_q),
        .o_first   (first),
        .o_second  (second),
        .o_first_lu(first_lu),
        .o_held_lu (held_lu),
        .o_co_issue(co_issue)
    );

    always_comb begin
        state_d    = state_q;
        held_d     = held_q;
        u_d        = u_q;
        v_d        = v_q;
        o_dec_hold = 1'b0;

        if (i_flush) begin
            state_d = ISSUE;
            held_d  = BUBBLE;
            u_d     = BUBBLE;
            v_d     = BUBBLE;
        end else if (i_stall) begin
            o_dec_hold = 1'b1;
        end else begin
            unique case (state_q)
                SPLIT: begin
                    o_dec_hold = 1'b1;
                    v_d        = BUBBLE;
                    if (held_lu) begin
                        u_d = BUBBLE;
                    end else begin
                        u_d     = held_q;
                        held_d  = BUBBLE;
                        state_d = ISSUE;
                    end
                end
                default: begin
                    u_d = BUBBLE;
                    v_d = BUBBLE;
                    if (first.valid && first_lu) begin
                        o_dec_hold = 1'b1;
                    end else if (first.valid) begin
                        u_d = first;
                        if (co_issue) begin
                            v_d = second;
                        end else if (second.valid) begin
                            held_d     = second;
                            state_d    = SPLIT;
                            o_dec_hold = 1'b1;
                        end
                    end
                end
            endcase
        end

        // Tracker mirrors whatever will sit in the U issue register.
        ld_vld_d = u_d.valid && u_d.load_en;
        ld_rd_d  = u_d.rd_addr;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= ISSUE;
            held_q   <= BUBBLE;
            u_q      <= BUBBLE;
            v_q      <= BUBBLE;
            ld_rd_q  <= 5'd0;
            ld_vld_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            held_q   <= held_d;
            u_q      <= u_d;
            v_q      <= v_d;
            ld_rd_q  <= ld_rd_d;
            ld_vld_q <= ld_vld_d;
        end
    end

    assign o_u_issue = u_q;
    assign o_v_issue = v_q;

endmodule

// File: tb/tb_issue_scheduler.sv
// Self-checking bench for issue_scheduler.
// Directed pairs, then random pairs against a queue-based model.
module tb_issue_scheduler;
    import pipeline_pkg::*;

    logic    clk = 1'b0;
    logic    rst_n;
    decode_t s0, s1;
    logic    fl, st;
    decode_t u, v;
    logic    hold;

    always #5 clk = ~clk;

    issue_scheduler dut (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_slot0   (s0),
        .i_slot1   (s1),
        .i_flush   (fl),
        .i_stall   (st),
        .o_u_issue (u),
        .o_v_issue (v),
        .o_dec_hold(hold)
    );

    int n_cmp = 0;
    int n_err = 0;

    decode_t     mu, mv, nu, nv;
    decode_t     pend[$];
    bit          e_hold;
    bit          took;
    logic [31:0] pc_ctr = 32'h1000;

    task automatic chk(input string tag, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    // kind: 0 R-ALU, 1 I-ALU, 2 load, 3 store, 4 branch, 5 system
    function automatic decode_t mk(input logic [31:0] pc, input int kind,
                                   input logic [4:0] rd,
                                   input logic [4:0] rs1,
                                   input logic [4:0] rs2);
        decode_t d;
        d          = '0;
        d.valid    = 1'b1;
        d.pc       = pc;
        d.rd_addr  = rd;
        d.rs1_addr = rs1;
        d.rs2_addr = rs2;
        d.imm      = pc ^ 32'h5a5a;
        case (kind)
            0: begin d.wren = 1; d.use_rs1 = 1; d.use_rs2 = 1; end
            1: begin d.wren = 1; d.use_rs1 = 1; end
            2: begin
                d.instr_type = LD_TYPE;
                d.load_en = 1; d.wren = 1; d.use_rs1 = 1;
            end
            3: begin
                d.instr_type = ST_TYPE;
                d.store_en = 1; d.use_rs1 = 1; d.use_rs2 = 1;
            end
            4: begin
                d.instr_type = BR_TYPE;
                d.prd_en = 1; d.use_rs1 = 1; d.use_rs2 = 1;
            end
            default: d.instr_type = SYS_TYPE;
        endcase
        return d;
    endfunction

    function automatic bit dep(input decode_t p, input decode_t c);
        if (!p.wren || p.rd_addr == 0) return 0;
        return (c.use_rs1 && c.rs1_addr == p.rd_addr) ||
               (c.use_rs2 && c.rs2_addr == p.rd_addr);
    endfunction

    function automatic bit alu_only(input decode_t d);
        return d.instr_type == ALU_TYPE && !d.load_en &&
               !d.store_en && !d.prd_en;
    endfunction

    function automatic bit ld_use(input decode_t x);
        return mu.valid && mu.load_en && dep(mu, x);
    endfunction

    function automatic bit same_rd(input decode_t a, input decode_t b);
        return a.wren && b.wren && a.rd_addr != 0 &&
               a.rd_addr == b.rd_addr;
    endfunction

    task automatic model(input decode_t a, input decode_t b,
                         input bit f, input bit s);
        decode_t q[$];
        took   = 0;
        e_hold = 0;
        nu     = mu;
        nv     = mv;
        if (f) begin
            nu = '0;
            nv = '0;
            pend.delete();
            took = 1;
        end else if (s) begin
            e_hold = 1;
        end else if (pend.size() != 0) begin
            e_hold = 1;
            nv = '0;
            if (ld_use(pend[0])) nu = '0;
            else nu = pend.pop_front();
        end else begin
            if (a.valid) q.push_back(a);
            if (b.valid) q.push_back(b);
            nu = '0;
            nv = '0;
            if (q.size() == 0) begin
                took = 1;
            end else if (ld_use(q[0])) begin
                e_hold = 1;
            end else begin
                nu = q[0];
                took = 1;
                if (q.size() == 2) begin
                    if (alu_only(q[1]) && !dep(q[0], q[1]) &&
                        !ld_use(q[1]) && !same_rd(q[0], q[1])) begin
                        nv = q[1];
                    end else begin
                        pend.push_back(q[1]);
                        e_hold = 1;
                    end
                end
            end
        end
    endtask

    task automatic check_outs();
        chk("u_valid", 32'(u.valid), 32'(mu.valid));
        if (mu.valid) chk("u_pc", u.pc, mu.pc);
        chk("v_valid", 32'(v.valid), 32'(mv.valid));
        if (mv.valid) chk("v_pc", v.pc, mv.pc);
    endtask

    task automatic cycle(input decode_t a, input decode_t b,
                         input bit f, input bit s);
        @(negedge clk);
        check_outs();
        s0 = a;
        s1 = b;
        fl = f;
        st = s;
        model(a, b, f, s);
        #1;
        chk("dec_hold", 32'(hold), 32'(e_hold));
        @(posedge clk);
        mu = nu;
        mv = nv;
    endtask

    decode_t bub;
    decode_t c0, c1;

    initial begin
        bub   = '0;
        rst_n = 1'b0;
        s0    = '0;
        s1    = '0;
        fl    = 1'b0;
        st    = 1'b0;
        mu    = '0;
        mv    = '0;
        #12;
        chk("rst_u_valid", 32'(u.valid), 32'd0);
        chk("rst_v_valid", 32'(v.valid), 32'd0);
        chk("rst_hold", 32'(hold), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // independent pair
        cycle(mk('h10, 1, 1, 0, 0), mk('h14, 0, 3, 4, 5), 0, 0);
        cycle(bub, bub, 0, 0);
        // dependent pair
        cycle(mk('h20, 1, 1, 0, 0), mk('h24, 0, 2, 1, 1), 0, 0);
        cycle(bub, bub, 0, 0);
        cycle(bub, bub, 0, 0);
        // load-use
        cycle(mk('h30, 2, 5, 2, 0), bub, 0, 0);
        cycle(mk('h34, 0, 6, 5, 0), mk('h38, 1, 7, 0, 0), 0, 0);
        cycle(mk('h34, 0, 6, 5, 0), mk('h38, 1, 7, 0, 0), 0, 0);
        cycle(bub, bub, 0, 0);
        // store and branch in slot1
        cycle(mk('h40, 0, 1, 2, 3), mk('h44, 3, 0, 4, 5), 0, 0);
        cycle(bub, bub, 0, 0);
        cycle(mk('h48, 0, 1, 2, 3), mk('h4c, 4, 0, 4, 5), 0, 0);
        cycle(bub, bub, 0, 0);
        cycle(bub, bub, 0, 0);
        // flush while split
        cycle(mk('h50, 0, 1, 2, 3), mk('h54, 3, 0, 4, 5), 0, 0);
        cycle(bub, bub, 1, 0);
        cycle(bub, bub, 0, 0);
        cycle(bub, bub, 0, 0);
        // stall mid-pair
        cycle(mk('h60, 1, 1, 0, 0), mk('h64, 0, 2, 1, 1), 0, 0);
        for (int i = 0; i < 3; i++) cycle(bub, bub, 0, 1);
        cycle(bub, bub, 0, 0);
        cycle(bub, bub, 0, 0);
        // x0 writes never conflict
        cycle(mk('h70, 1, 0, 0, 0), mk('h74, 0, 0, 0, 0), 0, 0);
        cycle(bub, bub, 0, 0);

        // reset during split
        cycle(mk('h80, 0, 1, 2, 3), mk('h84, 3, 0, 4, 5), 0, 0);
        @(negedge clk);
        s0 = '0;
        s1 = '0;
        rst_n = 1'b0;
        #1;
        chk("rst_split_u", 32'(u.valid), 32'd0);
        chk("rst_split_v", 32'(v.valid), 32'd0);
        chk("rst_split_hold", 32'(hold), 32'd0);
        mu = '0;
        mv = '0;
        pend.delete();
        @(negedge clk);
        rst_n = 1'b1;
        cycle(bub, bub, 0, 0);
        cycle(bub, bub, 0, 0);

        took = 1;
        c0 = '0;
        c1 = '0;
        for (int n = 0; n < 600; n++) begin
            if (took) begin
                c0 = mk(pc_ctr, int'($urandom_range(0, 5)),
                        5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)));
                c1 = mk(pc_ctr + 4, int'($urandom_range(0, 5)),
                        5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)));
                pc_ctr = pc_ctr + 8;
                if ($urandom_range(0, 9) < 2) c0.valid = 1'b0;
                if ($urandom_range(0, 9) < 2) c1.valid = 1'b0;
            end
            cycle(c0, c1, $urandom_range(0, 19) == 0,
                  $urandom_range(0, 7) == 0);
        end
        @(negedge clk);
        check_outs();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
